// File: rtl/misr_response_analyzer.sv
// Galois MISR output-response analyzer: compacts NUM_WORDS result words into a signature
// and compares it against a golden value. Optional idle abort enabled by MISR_TIMEOUT_EN.
module misr_response_analyzer #(
  parameter int unsigned WIDTH     = 17,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(17'h00009),
  parameter int unsigned NUM_WORDS = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] golden,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
`ifdef MISR_TIMEOUT_EN
  output logic             timeout,
`endif
  output logic [WIDTH-1:0] signature
);

  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);

  if (NUM_WORDS < 1 || NUM_WORDS > 65535 || TIMEOUT < 1) begin : g_bad_param
    $error("misr_response_analyzer: NUM_WORDS must be 1..65535 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, COMPACT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] golden_q;
  logic [WIDTH-1:0] misr_next_c;
  logic             accept_c;
  logic             last_word_c;

`ifdef MISR_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt;
`endif

  // A word arriving together with start belongs to the aborted run and is dropped.
  assign din_ready   = (state == COMPACT);
  assign accept_c    = din_valid && din_ready && !start;
  assign last_word_c = (cnt == CNT_W'(NUM_WORDS - 1));
  assign misr_next_c = {signature[WIDTH-2:0], 1'b0}
                     ^ (signature[WIDTH-1] ? POLY : '0)
                     ^ din;

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      signature <= '0;
      golden_q  <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
`ifdef MISR_TIMEOUT_EN
      idle_cnt  <= '0;
      timeout   <= 1'b0;
`endif
    end else if (start) begin
      state     <= COMPACT;
      signature <= seed;
      golden_q  <= golden;
      cnt       <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
`ifdef MISR_TIMEOUT_EN
      idle_cnt  <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      case (state)
        COMPACT: begin
          if (accept_c) begin
            signature <= misr_next_c;
            cnt       <= cnt + 1'b1;
`ifdef MISR_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
            if (last_word_c) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (misr_next_c == golden_q);
            end
          end
`ifdef MISR_TIMEOUT_EN
          else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end
        IDLE, DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
